regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 32x16 register file between NREQ write-back requesters, such as the ALU, load unit and multiply unit. Each requester uses a valid/ready handshake. A round-robin arbiter grants at most one request per cycle and drives a registered write to Rdst/Rdst_addr/Rwrite. The block also publishes a 32-bit pending-write mask, which decode uses for RAW hazard stalls.

Parameters:
NREQ, 3, number of write-back requesters (2..8)
DW, 16, register data width
AW, 5, register address width (32 registers)
ZERO_R0, 0, 1 = writes to address 0 are accepted but discarded (no Rwrite pulse)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
wb_hold  input  1  freeze: no grants while high
req_valid  input  NREQ  request i is presenting a write
req_ready  output  NREQ  grant/accept for request i (combinational)
req_addr  input  NREQ*AW  destination address of request i, slice [i*AW +: AW]
req_data  input  NREQ*DW  write data of request i, slice [i*DW +: DW]
Rwrite  output  1  register file write enable, 1-cycle pulse
Rdst_addr  output  AW  register file write address
Rdst  output  DW  register file write data
grant_id  output  3  index of the requester whose write is on Rwrite this cycle
pending_mask  output  32  bit a = 1 while any write to register a is queued or on the port

Behaviour:
- Reset (rst=1 at clk edge):
  - Rwrite=0, Rdst_addr=0, Rdst=0, grant_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is forced to all 0 while rst=1.
- Handshake:
  - Transfer for requester i occurs in a cycle where req_valid[i] && req_ready[i].
  - Once req_valid[i] rises, the requester holds addr/data stable and valid high until the transfer. The arbiter does not check this.
  - req_ready is one-hot or zero.
  - req_ready[i] may depend combinationally on req_valid and wb_hold only, never on req_addr/req_data.
- Arbitration:
  - If wb_hold=0 and any valid is set, grant the first valid requester searching from rr_ptr upward, modulo NREQ.
  - Grant sets req_ready[g]=1 the same cycle.
  - Next edge: rr_ptr <= (g+1) mod NREQ.
  - No grant: rr_ptr unchanged.
- Fairness: a continuously valid requester is granted within NREQ consecutive non-hold cycles.
- Write port:
  - Registered; latency exactly 1 cycle from transfer to the Rwrite pulse.
  - The edge after a transfer by g: Rwrite<=1, Rdst_addr<=req_addr[g], Rdst<=req_data[g], grant_id<=g.
  - If no transfer: Rwrite<=0, and Rdst/Rdst_addr/grant_id hold their last values.
  - Throughput: one write per cycle, back-to-back with no bubbles.
- ZERO_R0=1 with addr 0: the transfer completes normally (ready pulses, pointer advances) but Rwrite stays 0.
- wb_hold=1: req_ready=0 and rr_ptr frozen. A write already registered still completes its pulse that cycle. Subsequent Rwrite=0 until hold drops.
- pending_mask:
  - Combinational OR of onehot(req_addr[i]) for every i with req_valid[i]=1, plus onehot(Rdst_addr) when Rwrite=1.
  - A suppressed R0 write does not set bit 0.
  - All zero during/after reset until valid rises.
- Same destination from two requesters in one cycle: both are served in grant order, on consecutive writes. The later write wins in the register file. The bit stays set in pending_mask until the last write's Rwrite cycle ends.
- Reset mid-operation: any registered write is dropped (Rwrite=0 the next cycle). Requesters keep valid high; arbitration restarts from requester 0 on the first cycle with rst=0.
- grant_id width 3 is fixed. Bits above log2(NREQ) read 0.

Test Plan:
- Single request: reset, then req_valid=001 with addr=5, data=16'hABCD -> req_ready=001 the same cycle; next cycle Rwrite=1, Rdst_addr=5, Rdst=16'hABCD, grant_id=0; pending_mask[5]=1 for exactly 2 cycles.
- Round-robin: all three valid continuously with distinct addrs 1/2/3 and reset just released -> grants 0,1,2,0,1,2 on consecutive cycles; Rwrite high every cycle from cycle 2 onward.
- Hold: three requests pending, wb_hold=1 for 4 cycles -> req_ready=000, Rwrite=0 after the in-flight pulse, pending_mask bits 1/2/3 stay set; on release, grants resume from the frozen rr_ptr.
- Same address: req0 addr=7 data=1 and req1 addr=7 data=2 in the same cycle -> writes of 1 then 2 on consecutive cycles; pending_mask[7] drops only after the second Rwrite cycle.
- ZERO_R0=1, request addr=0 data=16'hFFFF -> ready pulses, Rwrite stays 0, pending_mask[0] clears after the transfer, rr_ptr advances.
- Reset mid-burst: assert rst in the cycle after a grant -> no Rwrite pulse in the next cycle; after rst drops, requester 0 is granted first.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the NREQ requesters and the register-file write port.
// The arbiter takes the slave side; requesters and the register file take the master side.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 16,
    parameter int AW   = 5
);
    logic                 wb_hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic                 Rwrite;
    logic [AW-1:0]        Rdst_addr;
    logic [DW-1:0]        Rdst;
    logic [2:0]           grant_id;
    logic [31:0]          pending_mask;

    modport master (
        output wb_hold, req_valid, req_addr, req_data,
        input  req_ready, Rwrite, Rdst_addr, Rdst, grant_id, pending_mask
    );

    modport slave (
        input  wb_hold, req_valid, req_addr, req_data,
        output req_ready, Rwrite, Rdst_addr, Rdst, grant_id, pending_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between NREQ
// write-back requesters, with a registered write and a pending-write mask for RAW stalls.
module regfile_wb_arbiter #(
    parameter int NREQ    = 3,
    parameter int DW      = 16,
    parameter int AW      = 5,
    parameter bit ZERO_R0 = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    logic [2:0]    rr_ptr;
    logic [2:0]    rr_ptr_next;
    logic          grant_valid;
    logic [2:0]    grant_idx;
    logic [3:0]    cand;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          wr_en;
    logic [31:0]   mask;

    // Grant search from rr_ptr upward, modulo NREQ; ready depends only on valid, hold and rst.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (!rst && !bus.wb_hold) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = {1'b0, rr_ptr} + 4'(k);
                if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
                for (int i = 0; i < NREQ; i++) begin
                    if (!grant_valid && cand == 4'(i) && bus.req_valid[i]) begin
                        grant_valid = 1'b1;
                        grant_idx   = 3'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        sel_addr      = '0;
        sel_data      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_valid && grant_idx == 3'(i)) begin
                bus.req_ready[i] = 1'b1;
                sel_addr         = bus.req_addr[i*AW +: AW];
                sel_data         = bus.req_data[i*DW +: DW];
            end
        end
    end

    assign rr_ptr_next = (grant_idx == 3'(NREQ - 1)) ? 3'd0 : grant_idx + 3'd1;
    // An R0 write still completes the handshake; only the register-file strobe is dropped.
    assign wr_en = !(ZERO_R0 && sel_addr == '0);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rr_ptr        <= '0;
            bus.Rwrite    <= 1'b0;
            bus.Rdst_addr <= '0;
            bus.Rdst      <= '0;
            bus.grant_id  <= '0;
        end else if (grant_valid) begin
            rr_ptr        <= rr_ptr_next;
            bus.Rwrite    <= wr_en;
            bus.Rdst_addr <= sel_addr;
            bus.Rdst      <= sel_data;
            bus.grant_id  <= grant_idx;
        end else begin
            bus.Rwrite    <= 1'b0;
        end
    end

    // Bits for every queued write plus the one currently on the port.
    always_comb begin
        mask = '0;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i]) mask = mask | (32'd1 << bus.req_addr[i*AW +: AW]);
            end
            if (bus.Rwrite) mask = mask | (32'd1 << bus.Rdst_addr);
        end
        bus.pending_mask = mask;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: single write, round-robin, hold, same address,
// mid-burst reset, and R0 suppression on a second instance built with ZERO_R0=1.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREQ(3), .DW(16), .AW(5)) bus0 ();
    regfile_wb_arbiter_if #(.NREQ(3), .DW(16), .AW(5)) bus1 ();

    regfile_wb_arbiter #(.NREQ(3), .DW(16), .AW(5), .ZERO_R0(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    regfile_wb_arbiter #(.NREQ(3), .DW(16), .AW(5), .ZERO_R0(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus0.wb_hold   = 1'b0;
        bus0.req_valid = '0;
        bus0.req_addr  = '0;
        bus0.req_data  = '0;
        bus1.wb_hold   = 1'b0;
        bus1.req_valid = '0;
        bus1.req_addr  = '0;
        bus1.req_data  = '0;
        tick();
        tick();
        settle();
        check("rst_rwrite",  32'(bus0.Rwrite),    32'd0);
        check("rst_addr",    32'(bus0.Rdst_addr), 32'd0);
        check("rst_data",    32'(bus0.Rdst),      32'd0);
        check("rst_gid",     32'(bus0.grant_id),  32'd0);
        check("rst_mask",    bus0.pending_mask,   32'd0);
        bus0.req_valid = 3'b001;
        settle();
        check("rst_ready_forced", 32'(bus0.req_ready), 32'd0);

        // Single request.
        tick();
        rst           = 1'b0;
        bus0.req_addr = {5'd0, 5'd0, 5'd5};
        bus0.req_data = {16'h0, 16'h0, 16'hABCD};
        settle();
        check("single_ready",  32'(bus0.req_ready), 32'b001);
        check("single_mask0",  bus0.pending_mask,   32'h0000_0020);
        check("single_nowr",   32'(bus0.Rwrite),    32'd0);
        tick();
        bus0.req_valid = 3'b000;
        settle();
        check("single_rwrite", 32'(bus0.Rwrite),    32'd1);
        check("single_waddr",  32'(bus0.Rdst_addr), 32'd5);
        check("single_wdata",  32'(bus0.Rdst),      32'hABCD);
        check("single_gid",    32'(bus0.grant_id),  32'd0);
        check("single_mask1",  bus0.pending_mask,   32'h0000_0020);
        check("single_ready2", 32'(bus0.req_ready), 32'd0);
        tick();
        settle();
        check("single_done",   32'(bus0.Rwrite),    32'd0);
        check("single_mask2",  bus0.pending_mask,   32'd0);
        check("single_hold_d", 32'(bus0.Rdst),      32'hABCD);

        // Round-robin straight out of reset: grants 0,1,2,0,1,2,0.
        tick();
        rst            = 1'b1;
        bus0.req_valid = 3'b111;
        bus0.req_addr  = {5'd3, 5'd2, 5'd1};
        bus0.req_data  = {16'h0033, 16'h0022, 16'h0011};
        settle();
        check("rr_in_rst_ready", 32'(bus0.req_ready), 32'd0);
        check("rr_in_rst_mask",  bus0.pending_mask,   32'd0);
        tick();
        rst = 1'b0;
        settle();
        check("rr_mask", bus0.pending_mask, 32'h0000_000E);
        for (int c = 0; c < 7; c++) begin
            check($sformatf("rr_ready_c%0d", c), 32'(bus0.req_ready), 32'd1 << (c % 3));
            if (c > 0) begin
                check($sformatf("rr_rwrite_c%0d", c), 32'(bus0.Rwrite),    32'd1);
                check($sformatf("rr_gid_c%0d", c),    32'(bus0.grant_id),  32'((c - 1) % 3));
                check($sformatf("rr_addr_c%0d", c),   32'(bus0.Rdst_addr), 32'((c - 1) % 3 + 1));
            end
            tick();
            settle();
        end

        // Hold: last grant was requester 0, so the frozen pointer is 1.
        bus0.wb_hold = 1'b1;
        settle();
        check("hold_ready0",   32'(bus0.req_ready), 32'd0);
        check("hold_inflight", 32'(bus0.Rwrite),    32'd1);
        check("hold_gid",      32'(bus0.grant_id),  32'd0);
        for (int c = 1; c < 4; c++) begin
            tick();
            settle();
            check($sformatf("hold_rwrite_c%0d", c), 32'(bus0.Rwrite),    32'd0);
            check($sformatf("hold_ready_c%0d", c),  32'(bus0.req_ready), 32'd0);
            check($sformatf("hold_mask_c%0d", c),   bus0.pending_mask,   32'h0000_000E);
        end
        tick();
        bus0.wb_hold = 1'b0;
        settle();
        check("hold_resume_ready", 32'(bus0.req_ready), 32'b010);
        tick();
        bus0.req_valid = 3'b000;
        settle();
        check("hold_resume_wr",  32'(bus0.Rwrite),    32'd1);
        check("hold_resume_gid", 32'(bus0.grant_id),  32'd1);
        check("hold_resume_adr", 32'(bus0.Rdst_addr), 32'd2);
        tick();
        settle();
        check("hold_idle", 32'(bus0.Rwrite), 32'd0);

        // Same destination from requesters 0 and 1; pointer is 2, wraps to 0.
        bus0.req_valid = 3'b011;
        bus0.req_addr  = {5'd0, 5'd7, 5'd7};
        bus0.req_data  = {16'h0, 16'h0002, 16'h0001};
        settle();
        check("same_ready0", 32'(bus0.req_ready), 32'b001);
        check("same_mask0",  bus0.pending_mask,   32'h0000_0080);
        tick();
        bus0.req_valid = 3'b010;
        settle();
        check("same_ready1", 32'(bus0.req_ready), 32'b010);
        check("same_wr1",    32'(bus0.Rwrite),    32'd1);
        check("same_data1",  32'(bus0.Rdst),      32'd1);
        check("same_mask1",  bus0.pending_mask,   32'h0000_0080);
        tick();
        bus0.req_valid = 3'b000;
        settle();
        check("same_wr2",    32'(bus0.Rwrite),    32'd1);
        check("same_data2",  32'(bus0.Rdst),      32'd2);
        check("same_gid2",   32'(bus0.grant_id),  32'd1);
        check("same_mask2",  bus0.pending_mask,   32'h0000_0080);
        tick();
        settle();
        check("same_mask3",  bus0.pending_mask,   32'd0);

        // R0 write without suppression is an ordinary write (pointer is 2).
        bus0.req_valid = 3'b100;
        bus0.req_addr  = {5'd0, 5'd0, 5'd0};
        bus0.req_data  = {16'h1234, 16'h0, 16'h0};
        settle();
        check("r0_plain_ready", 32'(bus0.req_ready), 32'b100);
        tick();
        bus0.req_valid = 3'b000;
        settle();
        check("r0_plain_wr",   32'(bus0.Rwrite),    32'd1);
        check("r0_plain_mask", bus0.pending_mask,   32'h0000_0001);
        tick();

        // Reset mid-burst: grant requester 1 (pointer 0 -> wait, pointer is 0 after req2).
        bus0.req_valid = 3'b111;
        bus0.req_addr  = {5'd11, 5'd10, 5'd9};
        bus0.req_data  = {16'h00C3, 16'h00B2, 16'h00A1};
        settle();
        check("mid_ready0", 32'(bus0.req_ready), 32'b001);
        tick();
        settle();
        check("mid_ready1", 32'(bus0.req_ready), 32'b010);
        tick();
        rst = 1'b1;
        settle();
        check("mid_pulse",     32'(bus0.Rwrite),    32'd1);
        check("mid_pulse_gid", 32'(bus0.grant_id),  32'd1);
        check("mid_rst_ready", 32'(bus0.req_ready), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        check("mid_dropped",   32'(bus0.Rwrite),    32'd0);
        check("mid_gid_rst",   32'(bus0.grant_id),  32'd0);
        check("mid_restart",   32'(bus0.req_ready), 32'b001);
        tick();
        bus0.req_valid = 3'b000;
        settle();
        check("mid_restart_wr",   32'(bus0.Rwrite),    32'd1);
        check("mid_restart_addr", 32'(bus0.Rdst_addr), 32'd9);
        tick();

        // ZERO_R0 instance: R0 write handshakes but produces no strobe; pointer advances.
        bus1.req_valid = 3'b001;
        bus1.req_addr  = {5'd0, 5'd0, 5'd0};
        bus1.req_data  = {16'h0, 16'h0, 16'hFFFF};
        settle();
        check("z0_ready", 32'(bus1.req_ready), 32'b001);
        check("z0_mask",  bus1.pending_mask,   32'h0000_0001);
        tick();
        bus1.req_valid = 3'b000;
        settle();
        check("z0_nowrite", 32'(bus1.Rwrite),  32'd0);
        check("z0_mask2",   bus1.pending_mask, 32'd0);
        tick();
        bus1.req_valid = 3'b011;
        bus1.req_addr  = {5'd0, 5'd4, 5'd4};
        bus1.req_data  = {16'h0, 16'h0044, 16'h0040};
        settle();
        check("z0_ptr_adv", 32'(bus1.req_ready), 32'b010);
        tick();
        bus1.req_valid = 3'b000;
        settle();
        check("z0_nonzero_wr",  32'(bus1.Rwrite), 32'd1);
        check("z0_nonzero_dat", 32'(bus1.Rdst),   32'h0044);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
